// File: rtl/seq_sum_engine_pkg.sv
// Shared types, defaults and the saturating adder for the series-sum engine.
package seq_sum_pkg;

  localparam int unsigned WIDTH_DEF     = 8;
  localparam int unsigned SUM_WIDTH_DEF = 16;

  // Working width of the generic saturating adder; SUM_WIDTH must stay below this.
  localparam int unsigned SAT_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [SAT_MAX_W-1:0] sum;
    logic                 ovf;
  } sat_res_t;

  // Adds two values that fit in 'width' bits; on carry out of 'width' bits the
  // result is all-ones in the low 'width' bits and ovf is set.
  function automatic sat_res_t sat_add(input logic [SAT_MAX_W-1:0] acc,
                                       input logic [SAT_MAX_W-1:0] term,
                                       input int unsigned          width);
    logic [SAT_MAX_W:0] full;
    logic [SAT_MAX_W:0] mask;
    sat_res_t           r;
    full  = {1'b0, acc} + {1'b0, term};
    mask  = ((SAT_MAX_W+1)'(1) << width) - (SAT_MAX_W+1)'(1);
    r.ovf = (full & ~mask) != '0;
    r.sum = r.ovf ? mask[SAT_MAX_W-1:0] : full[SAT_MAX_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/seq_sum_engine_if.sv
// Handshake and operand bus between the control unit and the series-sum engine.
interface seq_sum_engine_if
  import seq_sum_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEF,
  parameter int unsigned SUM_WIDTH = SUM_WIDTH_DEF
) ();

  logic                 start;
  logic                 abort;
  logic [WIDTH-1:0]     limit;
  logic [WIDTH-1:0]     step;
  logic                 busy;
  logic                 out_valid;
  logic [SUM_WIDTH-1:0] result;
  logic                 ovf;

  modport master (
    output start, abort, limit, step,
    input  busy, out_valid, result, ovf
  );

  modport slave (
    input  start, abort, limit, step,
    output busy, out_valid, result, ovf
  );

endinterface

// File: rtl/seq_sum_engine_sync_load_reg.sv
// Register with synchronous active-high clear and load enable; holds otherwise.
module sync_load_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear on reset, capture on load, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/seq_sum_engine.sv
// Arithmetic series sum 0 + s + 2s + ... up to the largest term <= limit,
// with start/busy/out_valid handshake and a held result.
module seq_sum_engine
  import seq_sum_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEF,
  parameter int unsigned SUM_WIDTH = SUM_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  seq_sum_engine_if.slave  bus
);

  state_e               state_d, state_q;
  logic                 cfg_load;
  logic [WIDTH-1:0]     lim_d, lim_q;
  logic [WIDTH-1:0]     step_d, step_q;
  logic                 a_load;
  logic [WIDTH:0]       a_d, a_q;
  logic                 acc_load;
  logic [SUM_WIDTH-1:0] acc_d, acc_q;
  logic                 result_load;
  logic [SUM_WIDTH-1:0] result_d, result_q;
  logic                 ovf_run_d, ovf_run_q;
  logic                 ovf_d, ovf_q;
  sat_res_t             sat;
  logic                 unused_sat_hi;

  sync_load_reg #(.W(WIDTH)) u_lim (
    .clk(clk), .reset(reset), .load(cfg_load), .d(lim_d), .q(lim_q)
  );

  sync_load_reg #(.W(WIDTH)) u_step (
    .clk(clk), .reset(reset), .load(cfg_load), .d(step_d), .q(step_q)
  );

  // Term counter is one bit wider than limit so a + step can never wrap.
  sync_load_reg #(.W(WIDTH+1)) u_a (
    .clk(clk), .reset(reset), .load(a_load), .d(a_d), .q(a_q)
  );

  sync_load_reg #(.W(SUM_WIDTH)) u_acc (
    .clk(clk), .reset(reset), .load(acc_load), .d(acc_d), .q(acc_q)
  );

  sync_load_reg #(.W(SUM_WIDTH)) u_result (
    .clk(clk), .reset(reset), .load(result_load), .d(result_d), .q(result_q)
  );

  // Next-state and datapath control; abort takes priority over accumulate.
  always_comb begin
    state_d     = state_q;
    cfg_load    = 1'b0;
    lim_d       = bus.limit;
    step_d      = (bus.step == '0) ? WIDTH'(1) : bus.step;
    a_load      = 1'b0;
    a_d         = a_q + {1'b0, step_q};
    acc_load    = 1'b0;
    sat         = sat_add(SAT_MAX_W'(acc_q), SAT_MAX_W'(a_q), SUM_WIDTH);
    acc_d       = sat.sum[SUM_WIDTH-1:0];
    result_load = 1'b0;
    result_d    = acc_q;
    ovf_run_d   = ovf_run_q;
    ovf_d       = ovf_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          cfg_load  = 1'b1;
          a_load    = 1'b1;
          a_d       = '0;
          acc_load  = 1'b1;
          acc_d     = '0;
          ovf_run_d = 1'b0;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (a_q <= {1'b0, lim_q}) begin
          acc_load  = 1'b1;
          a_load    = 1'b1;
          ovf_run_d = ovf_run_q | sat.ovf;
        end else begin
          result_load = 1'b1;
          ovf_d       = ovf_run_q;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign unused_sat_hi = ^sat.sum[SAT_MAX_W-1:SUM_WIDTH];

  // State, per-run overflow and reported overflow flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ovf_run_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ovf_run_q <= ovf_run_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_seq_sum_engine.sv
// Directed self-checking bench for seq_sum_engine (16-bit and 8-bit sum variants).
module tb_seq_sum_engine;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  seq_sum_engine_if #(.WIDTH(8), .SUM_WIDTH(16)) bus16 ();
  seq_sum_engine_if #(.WIDTH(8), .SUM_WIDTH(8))  bus8 ();

  seq_sum_engine #(.WIDTH(8), .SUM_WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .bus(bus16)
  );

  seq_sum_engine #(.WIDTH(8), .SUM_WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .bus(bus8)
  );

  typedef struct {
    bit          sel;       // 0: 16-bit sum DUT, 1: 8-bit sum DUT
    logic [7:0]  limit;
    logic [7:0]  step;
    logic [15:0] exp_result;
    logic        exp_ovf;
    int          exp_busy;  // cycles with busy high = terms + 1
  } vec_t;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic s, input logic [7:0] l, input logic [7:0] st);
    if (sel) begin
      bus8.start = s;  bus8.limit = l;  bus8.step = st;
    end else begin
      bus16.start = s; bus16.limit = l; bus16.step = st;
    end
  endtask

  function automatic logic get_busy(input bit sel);
    return sel ? bus8.busy : bus16.busy;
  endfunction

  function automatic logic get_valid(input bit sel);
    return sel ? bus8.out_valid : bus16.out_valid;
  endfunction

  function automatic logic [15:0] get_result(input bit sel);
    return sel ? {8'h00, bus8.result} : bus16.result;
  endfunction

  function automatic logic get_ovf(input bit sel);
    return sel ? bus8.ovf : bus16.ovf;
  endfunction

  // Start a run, scramble the operands after acceptance, count busy cycles until out_valid.
  task automatic run_vec(input bit sel, input logic [7:0] lim, input logic [7:0] stp,
                         output int busy_cnt, output bit got_valid);
    @(negedge clk);
    drive(sel, 1'b1, lim, stp);
    @(posedge clk); #1;
    drive(sel, 1'b0, ~lim, 8'd0);
    busy_cnt  = 0;
    got_valid = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (get_valid(sel)) begin
        got_valid = 1'b1;
        break;
      end
      if (get_busy(sel)) busy_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_valid(input bit sel, output bit got_valid);
    got_valid = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (get_valid(sel)) begin
        got_valid = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  vec_t vecs[11];

  initial begin
    int  bc;
    bit  gv;
    int  vcount;

    vecs[0]  = '{0, 8'd10,  8'd1,   16'd55,    1'b0, 12};
    vecs[1]  = '{0, 8'd10,  8'd3,   16'd18,    1'b0, 5};
    vecs[2]  = '{0, 8'd0,   8'd0,   16'd0,     1'b0, 2};
    vecs[3]  = '{0, 8'd255, 8'd1,   16'd32640, 1'b0, 257};
    vecs[4]  = '{0, 8'd100, 8'd7,   16'd735,   1'b0, 16};
    vecs[5]  = '{0, 8'd255, 8'd255, 16'd255,   1'b0, 3};
    vecs[6]  = '{0, 8'd5,   8'd10,  16'd0,     1'b0, 2};
    vecs[7]  = '{1, 8'd30,  8'd1,   16'd255,   1'b1, 32};
    vecs[8]  = '{1, 8'd4,   8'd1,   16'd10,    1'b0, 6};
    vecs[9]  = '{1, 8'd22,  8'd1,   16'd253,   1'b0, 24};
    vecs[10] = '{1, 8'd23,  8'd1,   16'd255,   1'b1, 25};

    reset = 1'b1;
    bus16.abort = 1'b0;
    bus8.abort  = 1'b0;
    drive(0, 1'b0, 8'd0, 8'd0);
    drive(1, 1'b0, 8'd0, 8'd0);
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rst%0d_busy", s),   32'(get_busy(s[0])),   32'd0);
      chk($sformatf("rst%0d_valid", s),  32'(get_valid(s[0])),  32'd0);
      chk($sformatf("rst%0d_result", s), 32'(get_result(s[0])), 32'd0);
      chk($sformatf("rst%0d_ovf", s),    32'(get_ovf(s[0])),    32'd0);
    end
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_vec(vecs[i].sel, vecs[i].limit, vecs[i].step, bc, gv);
      chk($sformatf("v%0d_valid", i),  32'(gv), 32'd1);
      chk($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'(vecs[i].exp_busy));
      chk($sformatf("v%0d_result", i), 32'(get_result(vecs[i].sel)), 32'(vecs[i].exp_result));
      chk($sformatf("v%0d_ovf", i),    32'(get_ovf(vecs[i].sel)), 32'(vecs[i].exp_ovf));
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid_drop", i), 32'(get_valid(vecs[i].sel)), 32'd0);
      chk($sformatf("v%0d_result_hold", i), 32'(get_result(vecs[i].sel)), 32'(vecs[i].exp_result));
    end

    // Abort on the 5th RUN edge after a completed limit=10 run; start pulse mid-run ignored.
    run_vec(0, 8'd10, 8'd1, bc, gv);
    chk("abort_pre_result", 32'(bus16.result), 32'd55);
    @(negedge clk);
    drive(0, 1'b1, 8'd20, 8'd1);
    @(posedge clk); #1;
    drive(0, 1'b0, 8'd20, 8'd1);
    @(posedge clk); #1;
    bus16.start = 1'b1;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    chk("abort_start_ignored_busy", 32'(bus16.busy), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    bus16.abort = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", 32'(bus16.busy), 32'd0);
    chk("abort_valid", 32'(bus16.out_valid), 32'd0);
    chk("abort_result", 32'(bus16.result), 32'd55);
    vcount = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (bus16.out_valid) vcount++;
    end
    bus16.abort = 1'b0;
    chk("abort_no_valid_after", 32'(vcount), 32'd0);
    chk("abort_result_hold", 32'(bus16.result), 32'd55);

    // Start held through DONE: one IDLE cycle, then the next run begins.
    @(negedge clk);
    drive(0, 1'b1, 8'd2, 8'd1);
    @(posedge clk); #1;
    wait_valid(0, gv);
    chk("b2b_first_valid", 32'(gv), 32'd1);
    chk("b2b_first_result", 32'(bus16.result), 32'd3);
    bus16.limit = 8'd4;
    @(posedge clk); #1;
    chk("b2b_idle_busy", 32'(bus16.busy), 32'd0);
    chk("b2b_idle_valid", 32'(bus16.out_valid), 32'd0);
    @(posedge clk); #1;
    chk("b2b_second_busy", 32'(bus16.busy), 32'd1);
    drive(0, 1'b0, 8'd0, 8'd0);
    wait_valid(0, gv);
    chk("b2b_second_valid", 32'(gv), 32'd1);
    chk("b2b_second_result", 32'(bus16.result), 32'd10);

    // Reset mid-RUN with start held high on both instances.
    @(negedge clk);
    drive(0, 1'b1, 8'd50, 8'd1);
    drive(1, 1'b1, 8'd50, 8'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mrst_busy16",   32'(bus16.busy),      32'd0);
    chk("mrst_busy8",    32'(bus8.busy),       32'd0);
    chk("mrst_valid16",  32'(bus16.out_valid), 32'd0);
    chk("mrst_result16", 32'(bus16.result),    32'd0);
    chk("mrst_result8",  32'(bus8.result),     32'd0);
    chk("mrst_ovf8",     32'(bus8.ovf),        32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 1'b0, 8'd0, 8'd0);
    drive(1, 1'b0, 8'd0, 8'd0);
    @(posedge clk); #1;
    chk("mrst_idle_busy16", 32'(bus16.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/seq_sum_engine.md
Name: seq_sum_engine

Overview:
Parametrised successor to the fixed 1-to-10 summing datapath. Computes the arithmetic series sum 0 + s + 2s + … up to and including the largest term ≤ limit. Datapath and control FSM live in one block, with a start/busy/out_valid handshake and a held result register. It sits between the control unit and the output display/port logic.

Parameters:
- WIDTH, 8, width of limit, step and the term counter.
- SUM_WIDTH, 16, width of accumulator and result; must be ≥ WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a new computation; sampled only in IDLE.
- abort  in  1  cancel a running computation; sampled only in RUN.
- limit  in  WIDTH  inclusive upper bound for terms; latched on accepted start.
- step  in  WIDTH  term increment; latched on accepted start; 0 is treated as 1.
- busy  out  1  high while state is RUN.
- out_valid  out  1  one-cycle pulse; result and ovf are updated.
- result  out  SUM_WIDTH  last completed sum; held until the next completion.
- ovf  out  1  sticky-per-run overflow flag; accompanies result.

Behaviour:
- One clock domain. Reset is synchronous and active-high, as already decided.
- Reset drives state to IDLE and clears busy, out_valid, result, ovf and all internal registers to 0. Reset wins over start and abort in the same cycle, and reset in any state returns to IDLE.
- States: IDLE, RUN, DONE. busy = (state == RUN). out_valid = (state == DONE), Moore-decoded.
- IDLE, start=1 at edge k:
  - latch lim_q = limit and step_q = (step == 0 ? 1 : step);
  - load a = 0, acc = 0, ovf_run = 0;
  - go to RUN.
- IDLE, start=0: hold state.
- RUN, each edge:
  - if abort=1: go to IDLE. result and ovf are unchanged and no out_valid is produced. Abort has priority over accumulate.
  - else if a ≤ lim_q: acc = sat(acc + a); a = a + step_q.
  - else (a > lim_q): result = acc, ovf = ovf_run, go to DONE.
- Term counter width: a is WIDTH+1 bits, so a + step never wraps. A term exceeding 2^WIDTH−1 always compares greater than lim_q and ends the run. Example: limit = 255, step = 1 terminates after adding 255.
- Accumulator: acc + a is computed at SUM_WIDTH+1 bits.
  - If the carry is set, acc saturates to all-ones and ovf_run is set.
  - Once saturated, acc stays all-ones for the rest of the run.
- Term count n = floor(lim_q / step_q) + 1, counting the 0 term.
  - Edges k+1 … k+n perform the adds.
  - Edge k+n+1 loads result and enters DONE, so out_valid is high for exactly the cycle after edge k+n+1.
  - Edge k+n+2 returns to IDLE.
- start during RUN or DONE is ignored and not queued. A start held high through DONE is accepted in the following IDLE cycle, giving back-to-back runs with one IDLE cycle between them.
- limit and step changes after acceptance have no effect on the current run.
- abort in IDLE or DONE has no effect.

Decomposition:
- Shared package seq_sum_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - localparam defaults for WIDTH and SUM_WIDTH;
  - the saturating-add function used by the accumulator.
- One sub-module, sync_load_reg: parametrised width, synchronous active-high reset, load enable, hold otherwise.
  - Instantiated for lim_q, step_q, a, acc and result.
  - The FSM stays inline in seq_sum_engine.

Test Plan:
- Reset then start with limit=10, step=1 at edge k → busy high for edges k+1…k+12, out_valid high only in the cycle after edge k+12, result=55, ovf=0; result holds 55 after out_valid drops.
- limit=10, step=3 → terms 0,3,6,9, result=18, out_valid after edge k+5; then limit=0, step=0 (treated as 1) → result=0, out_valid after edge k+2.
- WIDTH=8, SUM_WIDTH=8, limit=30, step=1 → result=255, ovf=1; a following run with limit=4 → result=10, ovf=0.
- limit=255, step=1, defaults → terminates with result=32640, no counter wrap, 257 busy cycles.
- Run limit=10, then start limit=20 with abort at the 5th RUN cycle → returns to IDLE, no out_valid, result stays 55; start pulses during RUN are ignored.
- Assert reset mid-RUN with start also high → next cycle IDLE, busy=0, result=0, ovf=0, out_valid=0.
